// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory-bus arbiter.
package mem_arbiter_pkg;

  localparam int          ARB_TIMEOUT = 255;
  localparam logic [3:0]  SEL_ALL     = 4'b1111;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_BUSY_MEM = 2'd1,
    ARB_BUSY_IF  = 2'd2
  } arb_state_e;

  function automatic logic is_busy(input arb_state_e s);
    return s != ARB_IDLE;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side (fetch and data ports) and bus-side signals of the arbiter.
// master: the arbiter itself; slave: the CPU core plus memory bus around it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_ce_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_data_o;
  logic              if_ready_o;

  logic              mem_ce_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_data_i;
  logic [3:0]        mem_sel_i;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_ready_o;

  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_data_o;
  logic [3:0]        bus_sel_o;
  logic [DATA_W-1:0] bus_data_i;
  logic              bus_ack_i;

  logic              stallreq_o;
  logic              err_o;

  modport master (
    input  if_ce_i, if_addr_i,
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i,
    input  bus_data_i, bus_ack_i,
    output if_data_o, if_ready_o, mem_data_o, mem_ready_o,
    output bus_req_o, bus_we_o, bus_addr_o, bus_data_o, bus_sel_o,
    output stallreq_o, err_o
  );

  modport slave (
    output if_ce_i, if_addr_i,
    output mem_ce_i, mem_we_i, mem_addr_i, mem_data_i, mem_sel_i,
    output bus_data_i, bus_ack_i,
    input  if_data_o, if_ready_o, mem_data_o, mem_ready_o,
    input  bus_req_o, bus_we_o, bus_addr_o, bus_data_o, bus_sel_o,
    input  stallreq_o, err_o
  );

endinterface

// File: rtl/mem_arbiter_wdog.sv
// Bus-ack watchdog: counts busy cycles without ack; expired flags the cycle
// whose end would bring the count to TIMEOUT.
module mem_arbiter_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  // Cleared when a transaction is granted, advanced on every unacked busy cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction fetches and data accesses onto one req/ack memory bus.
// Data port has fixed priority over fetch so the older instruction retires first.
//
// state        | meaning
// ARB_IDLE     | no bus cycle; arbitrate pending requests
// ARB_BUSY_MEM | data-port transaction on the bus, waiting for ack/timeout
// ARB_BUSY_IF  | fetch transaction on the bus, waiting for ack/timeout
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master mif
);

  arb_state_e state, state_nxt;
  logic       grant_mem, grant_if, finish, abort;
  logic       busy, expired;

  // A requester whose ready is high this cycle has been served; its ce is
  // still up only because it has not seen the pulse yet, so it must not win.
  logic mem_pending, if_pending;
  assign mem_pending = mif.mem_ce_i & ~mif.mem_ready_o;
  assign if_pending  = mif.if_ce_i  & ~mif.if_ready_o;
  assign busy        = is_busy(state);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle control strobes; ack beats a coincident timeout.
  always_comb begin
    state_nxt = state;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (mem_pending) begin
          grant_mem = 1'b1;
          state_nxt = ARB_BUSY_MEM;
        end else if (if_pending) begin
          grant_if  = 1'b1;
          state_nxt = ARB_BUSY_IF;
        end
      end
      ARB_BUSY_MEM, ARB_BUSY_IF: begin
        if (mif.bus_ack_i) begin
          finish    = 1'b1;
          state_nxt = ARB_IDLE;
        end else if (expired) begin
          abort     = 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  mem_arbiter_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant_mem | grant_if),
    .en      (busy & ~mif.bus_ack_i),
    .expired (expired)
  );

  // Registered bus request, read-data capture, ready pulses and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mif.bus_req_o   <= 1'b0;
      mif.bus_we_o    <= 1'b0;
      mif.bus_addr_o  <= {ADDR_W{1'b0}};
      mif.bus_data_o  <= {DATA_W{1'b0}};
      mif.bus_sel_o   <= 4'b0000;
      mif.if_data_o   <= {DATA_W{1'b0}};
      mif.if_ready_o  <= 1'b0;
      mif.mem_data_o  <= {DATA_W{1'b0}};
      mif.mem_ready_o <= 1'b0;
      mif.err_o       <= 1'b0;
    end else begin
      mif.if_ready_o  <= 1'b0;
      mif.mem_ready_o <= 1'b0;
      if (grant_mem) begin
        mif.bus_req_o  <= 1'b1;
        mif.bus_we_o   <= mif.mem_we_i;
        mif.bus_addr_o <= mif.mem_addr_i;
        mif.bus_data_o <= mif.mem_data_i;
        mif.bus_sel_o  <= mif.mem_sel_i;
      end else if (grant_if) begin
        mif.bus_req_o  <= 1'b1;
        mif.bus_we_o   <= 1'b0;
        mif.bus_addr_o <= mif.if_addr_i;
        mif.bus_data_o <= {DATA_W{1'b0}};
        mif.bus_sel_o  <= SEL_ALL;
      end
      if (finish || abort) begin
        mif.bus_req_o <= 1'b0;
        if (state == ARB_BUSY_MEM) begin
          mif.mem_ready_o <= 1'b1;
          // Stores leave the load register alone.
          if (!mif.bus_we_o) begin
            mif.mem_data_o <= finish ? mif.bus_data_i : {DATA_W{1'b0}};
          end
        end else begin
          mif.if_ready_o <= 1'b1;
          mif.if_data_o  <= finish ? mif.bus_data_i : {DATA_W{1'b0}};
        end
      end
      if (abort) begin
        mif.err_o <= 1'b1;
      end
    end
  end

  // Stall the pipeline while either port has an unanswered request.
  assign mif.stallreq_o = (mif.if_ce_i  & ~mif.if_ready_o) |
                          (mif.mem_ce_i & ~mif.mem_ready_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a bus responder with programmable ack
// delay, and a queue of expected (port, data) results popped on each ready.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    bit          is_mem;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  int ack_delay = 1;
  bit ack_en    = 1'b1;
  bit idle_ack  = 1'b0;
  int wait_cnt  = 0;

  logic [31:0] exp_if_data  = 32'h0;
  logic [31:0] exp_mem_data = 32'h0;

  function automatic logic [31:0] bus_model(input logic [31:0] a);
    return 32'h3C01_0001 + (a - 32'h0000_0100);
  endfunction

  // Bus responder: acks after ack_delay request cycles.
  always @(negedge clk) begin
    if (mif.bus_req_o === 1'b1) begin
      wait_cnt = wait_cnt + 1;
      if (ack_en && wait_cnt >= ack_delay) begin
        mif.bus_ack_i  = 1'b1;
        mif.bus_data_i = bus_model(mif.bus_addr_o);
      end else begin
        mif.bus_ack_i  = 1'b0;
        mif.bus_data_i = $urandom;
      end
    end else begin
      wait_cnt       = 0;
      mif.bus_ack_i  = idle_ack;
      mif.bus_data_i = $urandom;
    end
  end

  task automatic wait_ready(input int budget, output int cycles, output int req_cycles,
                            output bit addr_stable, output bit timed_out);
    logic [31:0] a0;
    bit seen;
    cycles = 0; req_cycles = 0; addr_stable = 1'b1; timed_out = 1'b1; seen = 1'b0; a0 = '0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (mif.bus_req_o === 1'b1) begin
        req_cycles++;
        if (!seen) begin seen = 1'b1; a0 = mif.bus_addr_o; end
        else if (mif.bus_addr_o !== a0) addr_stable = 1'b0;
      end
      if (mif.if_ready_o === 1'b1 || mif.mem_ready_o === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if (mif.bus_req_o !== 1'b0 || mif.bus_we_o !== 1'b0 || mif.bus_addr_o !== 32'h0 ||
        mif.bus_data_o !== 32'h0 || mif.bus_sel_o !== 4'h0 || mif.err_o !== 1'b0)
      begin n_fail++; $display("FAIL reset_bus: req=%b we=%b addr=%h sel=%h err=%b, required all zero",
        mif.bus_req_o, mif.bus_we_o, mif.bus_addr_o, mif.bus_sel_o, mif.err_o); end
    n_checks++;
    if (mif.if_ready_o !== 1'b0 || mif.mem_ready_o !== 1'b0 || mif.if_data_o !== 32'h0 ||
        mif.mem_data_o !== 32'h0 || mif.stallreq_o !== 1'b0)
      begin n_fail++; $display("FAIL reset_cpu: if_rdy=%b mem_rdy=%b if_d=%h mem_d=%h stall=%b, required all zero",
        mif.if_ready_o, mif.mem_ready_o, mif.if_data_o, mif.mem_data_o, mif.stallreq_o); end
    rst = 1'b1;
  endtask

  task automatic test_fetch;
    int cyc, rq; bit st, to; exp_t e; logic [31:0] od;
    @(negedge clk);
    ack_delay = 1;
    mif.if_ce_i = 1'b1; mif.if_addr_i = 32'h100;
    sb.push_back('{1'b0, 32'h3C01_0001});
    exp_if_data = 32'h3C01_0001;
    #1;
    n_checks++;
    if (mif.stallreq_o !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_pre: stall=%b required 1", mif.stallreq_o); end
    wait_ready(10, cyc, rq, st, to);
    n_checks++;
    if (to || cyc != 2) begin n_fail++; $display("FAIL fetch_latency: cycles=%0d timeout=%b required 2", cyc, to); end
    od = mif.mem_ready_o ? mif.mem_data_o : mif.if_data_o;
    e = sb.pop_front();
    n_checks++;
    if (mif.mem_ready_o !== e.is_mem || od !== e.data)
      begin n_fail++; $display("FAIL fetch_data: mem_port=%b data=%h required mem_port=%b data=%h", mif.mem_ready_o, od, e.is_mem, e.data); end
    n_checks++;
    if (mif.stallreq_o !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_release: stall=%b required 0", mif.stallreq_o); end
    mif.if_ce_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mif.if_ready_o !== 1'b0 || mif.bus_req_o !== 1'b0)
      begin n_fail++; $display("FAIL fetch_single_pulse: ready=%b req=%b required 0 0", mif.if_ready_o, mif.bus_req_o); end
  endtask

  task automatic test_contention;
    int cyc, rq; bit st, to; exp_t e; logic [31:0] od;
    @(negedge clk);
    mif.if_ce_i = 1'b1; mif.if_addr_i = 32'h180;
    mif.mem_ce_i = 1'b1; mif.mem_we_i = 1'b0; mif.mem_addr_i = 32'h200;
    mif.mem_data_i = 32'h0; mif.mem_sel_i = 4'b1111;
    sb.push_back('{1'b1, bus_model(32'h200)});
    sb.push_back('{1'b0, bus_model(32'h180)});
    exp_mem_data = bus_model(32'h200);
    exp_if_data  = bus_model(32'h180);
    @(negedge clk);
    n_checks++;
    if (mif.bus_req_o !== 1'b1 || mif.bus_addr_o !== 32'h200 || mif.bus_we_o !== 1'b0)
      begin n_fail++; $display("FAIL contention_mem_first: req=%b addr=%h we=%b required 1 00000200 0", mif.bus_req_o, mif.bus_addr_o, mif.bus_we_o); end
    wait_ready(10, cyc, rq, st, to);
    od = mif.mem_ready_o ? mif.mem_data_o : mif.if_data_o;
    e = sb.pop_front();
    n_checks++;
    if (to || mif.mem_ready_o !== e.is_mem || od !== e.data)
      begin n_fail++; $display("FAIL contention_first_result: mem_port=%b data=%h timeout=%b required mem_port=%b data=%h", mif.mem_ready_o, od, to, e.is_mem, e.data); end
    mif.mem_ce_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mif.bus_req_o !== 1'b1 || mif.bus_addr_o !== 32'h180 || mif.mem_ready_o !== 1'b0 || mif.bus_sel_o !== 4'b1111)
      begin n_fail++; $display("FAIL contention_if_grant: req=%b addr=%h mem_rdy=%b sel=%h required 1 00000180 0 f", mif.bus_req_o, mif.bus_addr_o, mif.mem_ready_o, mif.bus_sel_o); end
    wait_ready(10, cyc, rq, st, to);
    od = mif.mem_ready_o ? mif.mem_data_o : mif.if_data_o;
    e = sb.pop_front();
    n_checks++;
    if (to || cyc != 1 || mif.mem_ready_o !== e.is_mem || od !== e.data)
      begin n_fail++; $display("FAIL contention_second_result: mem_port=%b data=%h cycles=%0d required mem_port=%b data=%h cycles=1", mif.mem_ready_o, od, cyc, e.is_mem, e.data); end
    mif.if_ce_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mif.bus_req_o !== 1'b0) begin n_fail++; $display("FAIL contention_no_regrant: req=%b required 0", mif.bus_req_o); end
  endtask

  task automatic test_store;
    int cyc, rq; bit st, to; exp_t e; logic [31:0] od;
    @(negedge clk);
    mif.mem_ce_i = 1'b1; mif.mem_we_i = 1'b1; mif.mem_addr_i = 32'h40;
    mif.mem_data_i = 32'hDEAD_BEEF; mif.mem_sel_i = 4'b0011;
    sb.push_back('{1'b1, exp_mem_data});
    @(negedge clk);
    n_checks++;
    if (mif.bus_we_o !== 1'b1 || mif.bus_sel_o !== 4'b0011 || mif.bus_data_o !== 32'hDEAD_BEEF || mif.bus_addr_o !== 32'h40)
      begin n_fail++; $display("FAIL store_bus: we=%b sel=%h data=%h addr=%h required 1 3 deadbeef 00000040", mif.bus_we_o, mif.bus_sel_o, mif.bus_data_o, mif.bus_addr_o); end
    wait_ready(10, cyc, rq, st, to);
    od = mif.mem_ready_o ? mif.mem_data_o : mif.if_data_o;
    e = sb.pop_front();
    n_checks++;
    if (to || mif.mem_ready_o !== e.is_mem || od !== e.data)
      begin n_fail++; $display("FAIL store_result: mem_port=%b data=%h timeout=%b required mem_port=%b data=%h", mif.mem_ready_o, od, to, e.is_mem, e.data); end
    mif.mem_ce_i = 1'b0; mif.mem_we_i = 1'b0;
  endtask

  task automatic test_slow_bus;
    int cyc, rq; bit st, to; exp_t e; logic [31:0] od;
    @(negedge clk);
    ack_delay = 6;
    mif.if_ce_i = 1'b1; mif.if_addr_i = 32'h104;
    sb.push_back('{1'b0, bus_model(32'h104)});
    exp_if_data = bus_model(32'h104);
    wait_ready(20, cyc, rq, st, to);
    n_checks++;
    if (to || rq != 6 || !st)
      begin n_fail++; $display("FAIL slow_req_hold: req_cycles=%0d stable=%b timeout=%b required 6 1 0", rq, st, to); end
    od = mif.mem_ready_o ? mif.mem_data_o : mif.if_data_o;
    e = sb.pop_front();
    n_checks++;
    if (mif.mem_ready_o !== e.is_mem || od !== e.data)
      begin n_fail++; $display("FAIL slow_result: mem_port=%b data=%h required mem_port=%b data=%h", mif.mem_ready_o, od, e.is_mem, e.data); end
    mif.if_ce_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mif.if_ready_o !== 1'b0) begin n_fail++; $display("FAIL slow_single_pulse: ready=%b required 0", mif.if_ready_o); end
    ack_delay = 1;
  endtask

  task automatic test_idle_ack;
    bit bad = 1'b0;
    @(negedge clk);
    idle_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mif.bus_req_o !== 1'b0 || mif.if_ready_o !== 1'b0 || mif.mem_ready_o !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad || mif.if_data_o !== exp_if_data)
      begin n_fail++; $display("FAIL idle_ack_ignored: activity=%b if_data=%h required 0 %h", bad, mif.if_data_o, exp_if_data); end
    idle_ack = 1'b0;
  endtask

  task automatic test_timeout;
    int cyc, rq; bit st, to; exp_t e; logic [31:0] od;
    @(negedge clk);
    ack_en = 1'b0;
    mif.mem_ce_i = 1'b1; mif.mem_we_i = 1'b0; mif.mem_addr_i = 32'h300; mif.mem_sel_i = 4'b1111;
    sb.push_back('{1'b1, 32'h0});
    n_checks++;
    if (mif.mem_data_o !== exp_mem_data)
      begin n_fail++; $display("FAIL timeout_precond: mem_data=%h required %h", mif.mem_data_o, exp_mem_data); end
    wait_ready(400, cyc, rq, st, to);
    n_checks++;
    if (to || rq != 255 || mif.bus_req_o !== 1'b0 || mif.err_o !== 1'b1)
      begin n_fail++; $display("FAIL timeout_abort: req_cycles=%0d req=%b err=%b timeout=%b required 255 0 1 0", rq, mif.bus_req_o, mif.err_o, to); end
    od = mif.mem_ready_o ? mif.mem_data_o : mif.if_data_o;
    e = sb.pop_front();
    n_checks++;
    if (mif.mem_ready_o !== e.is_mem || od !== e.data)
      begin n_fail++; $display("FAIL timeout_result: mem_port=%b data=%h required mem_port=%b data=%h", mif.mem_ready_o, od, e.is_mem, e.data); end
    exp_mem_data = 32'h0;
    mif.mem_ce_i = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    mif.mem_ce_i = 1'b1; mif.mem_addr_i = 32'h204;
    sb.push_back('{1'b1, bus_model(32'h204)});
    exp_mem_data = bus_model(32'h204);
    wait_ready(10, cyc, rq, st, to);
    od = mif.mem_ready_o ? mif.mem_data_o : mif.if_data_o;
    e = sb.pop_front();
    n_checks++;
    if (to || mif.mem_ready_o !== e.is_mem || od !== e.data || mif.err_o !== 1'b1)
      begin n_fail++; $display("FAIL timeout_sticky: mem_port=%b data=%h err=%b required mem_port=%b data=%h err=1", mif.mem_ready_o, od, mif.err_o, e.is_mem, e.data); end
    mif.mem_ce_i = 1'b0;
  endtask

  task automatic test_reset_mid;
    int cyc, rq; bit st, to; exp_t e; logic [31:0] od; bit bad = 1'b0;
    @(negedge clk);
    ack_en = 1'b0;
    mif.if_ce_i = 1'b1; mif.if_addr_i = 32'h500;
    @(negedge clk);
    n_checks++;
    if (mif.bus_req_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: req=%b required 1", mif.bus_req_o); end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (mif.bus_req_o !== 1'b0 || mif.err_o !== 1'b0 || mif.if_ready_o !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_async: req=%b err=%b ready=%b required 0 0 0", mif.bus_req_o, mif.err_o, mif.if_ready_o); end
    repeat (2) begin
      @(negedge clk);
      if (mif.if_ready_o !== 1'b0 || mif.bus_req_o !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin n_fail++; $display("FAIL rstmid_held: activity=%b required 0", bad); end
    ack_en = 1'b1;
    rst = 1'b1;
    sb.push_back('{1'b0, bus_model(32'h500)});
    wait_ready(10, cyc, rq, st, to);
    od = mif.mem_ready_o ? mif.mem_data_o : mif.if_data_o;
    e = sb.pop_front();
    n_checks++;
    if (to || cyc != 2 || mif.mem_ready_o !== e.is_mem || od !== e.data)
      begin n_fail++; $display("FAIL rstmid_rearb: mem_port=%b data=%h cycles=%0d required mem_port=%b data=%h cycles=2", mif.mem_ready_o, od, cyc, e.is_mem, e.data); end
    mif.if_ce_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    mif.if_ce_i = 1'b0; mif.if_addr_i = '0;
    mif.mem_ce_i = 1'b0; mif.mem_we_i = 1'b0; mif.mem_addr_i = '0;
    mif.mem_data_i = '0; mif.mem_sel_i = '0;
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_slow_bus();
    test_idle_ack();
    test_timeout();
    test_reset_mid();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: left=%0d required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded, required completion");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one external unified memory bus between the CPU's instruction-fetch port (rom_*) and data-access port (ram_*).
- Serialises the two requesters through a multi-cycle req/ack bus transaction.
- Returns data and a one-cycle ready pulse to each requester.
- Drives a stall request into ctrl while any request is outstanding.
- Sits between the CPU core and the memory/SoC bus.

Parameters:
ADDR_W, 32, address width of both requesters and the bus
DATA_W, 32, data width
TIMEOUT, 255, max cycles waiting for bus_ack_i before a transaction is aborted (8-bit counter)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-low
if_ce_i  input  1  fetch request, held until if_ready_o
if_addr_i  input  ADDR_W  fetch address
if_data_o  output  DATA_W  fetched instruction
if_ready_o  output  1  one-cycle pulse, fetch complete
mem_ce_i  input  1  data request, held until mem_ready_o
mem_we_i  input  1  1 = write
mem_addr_i  input  ADDR_W  data address
mem_data_i  input  DATA_W  store data
mem_sel_i  input  4  byte-lane enables
mem_data_o  output  DATA_W  load data
mem_ready_o  output  1  one-cycle pulse, data access complete
bus_req_o  output  1  bus request, held until bus_ack_i
bus_we_o  output  1  bus write enable
bus_addr_o  output  ADDR_W  bus address
bus_data_o  output  DATA_W  bus write data
bus_sel_o  output  4  bus byte enables
bus_data_i  input  DATA_W  bus read data, valid with bus_ack_i
bus_ack_i  input  1  bus completion
stallreq_o  output  1  to ctrl; pipeline stall request
err_o  output  1  sticky timeout flag

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM=IDLE, timeout counter=0. Assertion mid-transaction drops bus_req_o immediately; no ready pulse is issued.
- FSM states: IDLE, BUSY_MEM, BUSY_IF.
- IDLE arbitration, fixed priority, MEM over IF (the older instruction must retire first):
  - mem_ce_i -> latch we/addr/data/sel, go to BUSY_MEM.
  - else if_ce_i -> latch addr, we=0, sel=4'b1111, go to BUSY_IF.
- All bus_* outputs are registered from the latched request. bus_req_o=1 throughout BUSY_*, 0 in IDLE.
- BUSY_* with bus_ack_i=1:
  - Read: capture bus_data_i into if_data_o or mem_data_o.
  - Pulse the matching ready for exactly one cycle (the cycle after ack).
  - bus_req_o falls; return to IDLE.
- Latency: ce sampled in IDLE at edge t -> bus_req_o high after t -> ack sampled at edge t+1 at earliest -> ready high after t+1. Minimum 2 cycles; throughput 1 transaction per 2 cycles.
- A new grant can be made on the edge where ready is high, i.e. in the IDLE cycle that follows the ack.
- Writes: mem_data_o holds its previous value. mem_ready_o still pulses.
- if_data_o and mem_data_o hold their last captured value until the next read of the same port.
- bus_ack_i in IDLE is ignored.
- ce deasserted while BUSY: the transaction completes on the bus and the ready pulse is still issued; the requester ignores it.
- Timeout: counter clears on entry to BUSY_* and increments each BUSY cycle without ack. When it reaches TIMEOUT:
  - drop bus_req_o;
  - set err_o (sticky until reset);
  - capture data as 0;
  - pulse ready;
  - go to IDLE.
- stallreq_o (combinational) = (if_ce_i & ~if_ready_o) | (mem_ce_i & ~mem_ready_o).
- Ack and timeout in the same cycle: ack wins; err_o is not set.

Decomposition:
- Shared header defines.h:
  - state encodings `ArbIdle/`ArbBusyMem/`ArbBusyIf (2-bit);
  - `ArbTimeout default;
  - reuse of existing `RegBus/`InstAddrBus widths.
- One sub-module: arb_wdog, the timeout counter with clear/enable inputs and an expired output.

Test Plan:
1. Single fetch: if_ce_i=1, addr=0x100; bus acks 1 cycle after req with 0x3C010001 -> if_data_o=0x3C010001, if_ready_o pulses once, 2 cycles total; stallreq_o=1 until the pulse.
2. Contention: if_ce_i and mem_ce_i both high in IDLE (mem load 0x200) -> MEM granted first (bus_addr_o=0x200), IF granted in the IDLE cycle that follows the MEM ack.
3. Store: mem_we_i=1, addr=0x40, data=0xDEADBEEF, sel=4'b0011 -> bus_we_o=1, bus_sel_o=4'b0011, bus_data_o=0xDEADBEEF; mem_data_o unchanged; mem_ready_o pulses.
4. Slow bus: ack delayed 5 cycles -> bus_req_o/bus_addr_o stable for 6 cycles; exactly one ready pulse.
5. Timeout: no ack -> after 255 BUSY cycles bus_req_o=0, err_o=1 (sticky), mem_data_o=0, mem_ready_o pulses.
6. Reset mid-transaction: rst low while BUSY_IF -> bus_req_o=0 asynchronously, no if_ready_o; after release the FSM is in IDLE and re-arbitrates.
